// File: rtl/regfile_2w2r_sb_if.sv
// Bus bundle for the 2-write/2-read register file: decode read ports,
// ALU/load writeback ports, PC increment and the load scoreboard mark port.
interface regfile_2w2r_sb_if #(
  parameter int DW = 32,
  parameter int AW = 4
);
  logic [AW-1:0] RA;
  logic [AW-1:0] RB;
  logic [DW-1:0] A;
  logic [DW-1:0] B;
  logic          BUSYA;
  logic          BUSYB;
  logic          WE0;
  logic [AW-1:0] WA0;
  logic [DW-1:0] WD0;
  logic          WE1;
  logic [AW-1:0] WA1;
  logic [DW-1:0] WD1;
  logic          PCEN;
  logic [DW-1:0] PC;
  logic          MARKEN;
  logic [AW-1:0] MARKA;

  modport master (
    output RA, RB, WE0, WA0, WD0, WE1, WA1, WD1, PCEN, MARKEN, MARKA,
    input  A, B, BUSYA, BUSYB, PC
  );

  modport slave (
    input  RA, RB, WE0, WA0, WD0, WE1, WA1, WD1, PCEN, MARKEN, MARKA,
    output A, B, BUSYA, BUSYB, PC
  );
endinterface

// File: rtl/regfile_2w2r_sb.sv
// Register file with two combinational read ports, ALU and load write ports,
// an auto-incrementing PC entry and a per-register outstanding-load scoreboard.
module regfile_2w2r_sb #(
  parameter int DW     = 32,
  parameter int AW     = 4,
  parameter int NREG   = 16,
  parameter int PCIDX  = 15,
  parameter int PCINC  = 4,
  parameter int BYPASS = 1
) (
  input logic              CLK,
  input logic              RST,
  regfile_2w2r_sb_if.slave bus
);

  localparam logic [AW:0]   NREG_W  = (AW+1)'(NREG);
  localparam logic [AW-1:0] PC_A    = AW'(PCIDX);
  localparam logic [DW-1:0] PC_STEP = DW'(PCINC);

  logic [NREG-1:0][DW-1:0] regs_q, regs_d;
  logic [NREG-1:0]         busy_q, busy_d;
  logic                    we0_s, we1_s, mark_s;
  logic [DW-1:0]           a_s, b_s;
  logic                    busya_s, busyb_s;

  function automatic logic in_range(input logic [AW-1:0] addr);
    return ({1'b0, addr} < NREG_W);
  endfunction

  // Qualified write/mark strobes; out-of-range targets and PC marks are dropped
  always_comb begin
    we0_s  = bus.WE0 && in_range(bus.WA0);
    we1_s  = bus.WE1 && in_range(bus.WA1);
    mark_s = bus.MARKEN && in_range(bus.MARKA) && (bus.MARKA != PC_A);
  end

  // Next-state: load port beats ALU port beats PC increment; a new mark beats the load clear
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int i = 0; i < NREG; i++) begin
      if (we1_s && (bus.WA1 == AW'(i))) begin
        regs_d[i] = bus.WD1;
      end else if (we0_s && (bus.WA0 == AW'(i))) begin
        regs_d[i] = bus.WD0;
      end else if ((i == PCIDX) && bus.PCEN) begin
        regs_d[i] = regs_q[i] + PC_STEP;
      end else begin
        regs_d[i] = regs_q[i];
      end
      if (mark_s && (bus.MARKA == AW'(i))) begin
        busy_d[i] = 1'b1;
      end else if (we1_s && (bus.WA1 == AW'(i))) begin
        busy_d[i] = 1'b0;
      end else begin
        busy_d[i] = busy_q[i];
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      regs_q <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  // Read port A; a forwarded load result is no longer considered busy
  always_comb begin
    if ((BYPASS != 0) && we1_s && (bus.WA1 == bus.RA)) begin
      a_s     = bus.WD1;
      busya_s = 1'b0;
    end else if ((BYPASS != 0) && we0_s && (bus.WA0 == bus.RA)) begin
      a_s     = bus.WD0;
      busya_s = busy_q[bus.RA];
    end else if (in_range(bus.RA)) begin
      a_s     = regs_q[bus.RA];
      busya_s = busy_q[bus.RA];
    end else begin
      a_s     = '0;
      busya_s = 1'b0;
    end
  end

  // Read port B, same rules as port A
  always_comb begin
    if ((BYPASS != 0) && we1_s && (bus.WA1 == bus.RB)) begin
      b_s     = bus.WD1;
      busyb_s = 1'b0;
    end else if ((BYPASS != 0) && we0_s && (bus.WA0 == bus.RB)) begin
      b_s     = bus.WD0;
      busyb_s = busy_q[bus.RB];
    end else if (in_range(bus.RB)) begin
      b_s     = regs_q[bus.RB];
      busyb_s = busy_q[bus.RB];
    end else begin
      b_s     = '0;
      busyb_s = 1'b0;
    end
  end

  assign bus.A     = a_s;
  assign bus.B     = b_s;
  assign bus.BUSYA = busya_s;
  assign bus.BUSYB = busyb_s;
  assign bus.PC    = regs_q[PCIDX];

endmodule

// File: tb/tb_regfile_2w2r_sb.sv
// Directed scoreboard bench: stimulus queues expected values, a negedge monitor
// pops and compares them against a bypassing and a non-bypassing instance.
module tb_regfile_2w2r_sb;
  localparam int K_A = 0, K_B = 1, K_BA = 2, K_BB = 3, K_PC = 4, K_NA = 5, K_NB = 6, K_NBB = 7;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       tag;
  } exp_t;

  logic clk;
  logic rst;
  exp_t sb_q[$];
  int   n_checks;
  int   n_fail;

  regfile_2w2r_sb_if #(.DW(32), .AW(4)) bus_bp ();
  regfile_2w2r_sb_if #(.DW(32), .AW(4)) bus_nb ();

  regfile_2w2r_sb #(.BYPASS(1)) u_bp (.CLK(clk), .RST(rst), .bus(bus_bp));
  regfile_2w2r_sb #(.BYPASS(0)) u_nb (.CLK(clk), .RST(rst), .bus(bus_nb));

  assign bus_nb.RA     = bus_bp.RA;
  assign bus_nb.RB     = bus_bp.RB;
  assign bus_nb.WE0    = bus_bp.WE0;
  assign bus_nb.WA0    = bus_bp.WA0;
  assign bus_nb.WD0    = bus_bp.WD0;
  assign bus_nb.WE1    = bus_bp.WE1;
  assign bus_nb.WA1    = bus_bp.WA1;
  assign bus_nb.WD1    = bus_bp.WD1;
  assign bus_nb.PCEN   = bus_bp.PCEN;
  assign bus_nb.MARKEN = bus_bp.MARKEN;
  assign bus_nb.MARKA  = bus_bp.MARKA;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] actual(input int kind);
    case (kind)
      K_A:     return bus_bp.A;
      K_B:     return bus_bp.B;
      K_BA:    return {31'd0, bus_bp.BUSYA};
      K_BB:    return {31'd0, bus_bp.BUSYB};
      K_PC:    return bus_bp.PC;
      K_NA:    return bus_nb.A;
      K_NB:    return bus_nb.B;
      K_NBB:   return {31'd0, bus_nb.BUSYB};
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  // Monitor: compare every expectation queued during this cycle
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      exp_t e;
      logic [31:0] got;
      e   = sb_q.pop_front();
      got = actual(e.kind);
      n_checks++;
      if (got !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h at %0t", e.tag, got, e.exp, $time);
      end
    end
  end

  task automatic expect_v(input int kind, input logic [31:0] v, input string tag);
    exp_t e;
    e.kind = kind;
    e.exp  = v;
    e.tag  = tag;
    sb_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    rst           = 1'b0;
    bus_bp.WE0    = 1'b0;
    bus_bp.WE1    = 1'b0;
    bus_bp.PCEN   = 1'b0;
    bus_bp.MARKEN = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus_bp.RA = 4'd0;  bus_bp.RB = 4'd0;
    bus_bp.WE0 = 1'b0; bus_bp.WA0 = 4'd0; bus_bp.WD0 = 32'd0;
    bus_bp.WE1 = 1'b0; bus_bp.WA1 = 4'd0; bus_bp.WD1 = 32'd0;
    bus_bp.PCEN = 1'b0; bus_bp.MARKEN = 1'b0; bus_bp.MARKA = 4'd0;

    // Reset state and PC increments
    step(); bus_bp.PCEN = 1'b1; bus_bp.RA = 4'd0; bus_bp.RB = 4'd14;
    expect_v(K_PC, 32'd0, "pc_rst"); expect_v(K_A, 32'd0, "a_rst"); expect_v(K_B, 32'd0, "b_rst");
    expect_v(K_BA, 32'd0, "busya_rst"); expect_v(K_BB, 32'd0, "busyb_rst");
    step(); bus_bp.PCEN = 1'b1; expect_v(K_PC, 32'd4, "pc_inc1");
    step(); bus_bp.PCEN = 1'b1; expect_v(K_PC, 32'd8, "pc_inc2");
    step(); expect_v(K_PC, 32'd12, "pc_inc3");
    for (int i = 0; i < 8; i++) begin
      step(); bus_bp.RA = 4'(i); bus_bp.RB = 4'(14 - i);
      expect_v(K_A, 32'd0, "reg_zero_a"); expect_v(K_B, 32'd0, "reg_zero_b");
      expect_v(K_PC, 32'd12, "pc_hold");
    end

    // Pending increment is not forwarded; then preload and wrap
    step(); bus_bp.PCEN = 1'b1; bus_bp.RA = 4'd15; expect_v(K_A, 32'd12, "pc_no_fwd");
    step(); bus_bp.PCEN = 1'b1; bus_bp.RA = 4'd15;
    bus_bp.WE0 = 1'b1; bus_bp.WA0 = 4'd15; bus_bp.WD0 = 32'hFFFF_FFFC;
    expect_v(K_PC, 32'd16, "pc_pre_load"); expect_v(K_A, 32'hFFFF_FFFC, "pc_wr_bypass");
    expect_v(K_NA, 32'd16, "nb_pc_read");
    step(); bus_bp.PCEN = 1'b1; bus_bp.RA = 4'd15; expect_v(K_PC, 32'hFFFF_FFFC, "pc_loaded");
    step(); bus_bp.RA = 4'd15; expect_v(K_PC, 32'd0, "pc_wrap"); expect_v(K_A, 32'd0, "pc_wrap_a");

    // Dual write same address: port 1 wins, forwarded and stored
    step(); bus_bp.RA = 4'd3; bus_bp.RB = 4'd3;
    bus_bp.WE0 = 1'b1; bus_bp.WA0 = 4'd3; bus_bp.WD0 = 32'hAAAA_0000;
    bus_bp.WE1 = 1'b1; bus_bp.WA1 = 4'd3; bus_bp.WD1 = 32'h5555_FFFF;
    expect_v(K_A, 32'h5555_FFFF, "dual_bypass_a"); expect_v(K_B, 32'h5555_FFFF, "dual_bypass_b");
    expect_v(K_NA, 32'd0, "nb_dual_old");
    step(); bus_bp.RA = 4'd3;
    expect_v(K_A, 32'h5555_FFFF, "dual_stored"); expect_v(K_NA, 32'h5555_FFFF, "nb_dual_stored");
    step(); bus_bp.RA = 4'd4; bus_bp.WE0 = 1'b1; bus_bp.WA0 = 4'd4; bus_bp.WD0 = 32'hCAFE_0004;
    expect_v(K_A, 32'hCAFE_0004, "alu_bypass"); expect_v(K_NA, 32'd0, "nb_alu_old");
    step(); bus_bp.RA = 4'd4; expect_v(K_A, 32'hCAFE_0004, "alu_stored");

    // Scoreboard mark then load clear with forwarding
    step(); bus_bp.MARKEN = 1'b1; bus_bp.MARKA = 4'd5; bus_bp.RB = 4'd5;
    expect_v(K_BB, 32'd0, "busy_before_mark");
    step(); bus_bp.RB = 4'd5; expect_v(K_BB, 32'd1, "busy_marked");
    step(); bus_bp.RB = 4'd5; bus_bp.WE1 = 1'b1; bus_bp.WA1 = 4'd5; bus_bp.WD1 = 32'h1234_5678;
    expect_v(K_BB, 32'd0, "busy_fwd_clear"); expect_v(K_B, 32'h1234_5678, "load_bypass");
    expect_v(K_NBB, 32'd1, "nb_busy_held"); expect_v(K_NB, 32'd0, "nb_load_old");
    step(); bus_bp.RB = 4'd5;
    expect_v(K_BB, 32'd0, "busy_cleared"); expect_v(K_B, 32'h1234_5678, "load_stored");
    expect_v(K_NBB, 32'd0, "nb_busy_cleared");

    // Mark and load to same register: busy stays set; ALU write leaves busy alone
    step(); bus_bp.RA = 4'd7; bus_bp.MARKEN = 1'b1; bus_bp.MARKA = 4'd7;
    bus_bp.WE1 = 1'b1; bus_bp.WA1 = 4'd7; bus_bp.WD1 = 32'h11;
    expect_v(K_A, 32'h11, "mark_ld_bypass"); expect_v(K_BA, 32'd0, "mark_ld_busy_fwd");
    step(); bus_bp.RA = 4'd7; expect_v(K_A, 32'h11, "mark_ld_data"); expect_v(K_BA, 32'd1, "mark_wins");
    step(); bus_bp.RA = 4'd7; bus_bp.WE0 = 1'b1; bus_bp.WA0 = 4'd7; bus_bp.WD0 = 32'h22;
    expect_v(K_A, 32'h22, "alu_fwd_busy_reg"); expect_v(K_BA, 32'd1, "alu_no_clear_fwd");
    step(); bus_bp.RA = 4'd7; expect_v(K_A, 32'h22, "alu_stored7"); expect_v(K_BA, 32'd1, "alu_no_clear");

    // PC write overrides increment; marks to PC ignored
    step(); bus_bp.PCEN = 1'b1; bus_bp.WE0 = 1'b1; bus_bp.WA0 = 4'd15; bus_bp.WD0 = 32'h100;
    expect_v(K_PC, 32'd0, "pc_before_wr");
    step(); bus_bp.RA = 4'd15; bus_bp.MARKEN = 1'b1; bus_bp.MARKA = 4'd15;
    expect_v(K_PC, 32'h100, "pc_wr_no_inc"); expect_v(K_BA, 32'd0, "pc_busy_pre");
    step(); bus_bp.RA = 4'd15; bus_bp.PCEN = 1'b1;
    bus_bp.WE1 = 1'b1; bus_bp.WA1 = 4'd15; bus_bp.WD1 = 32'h200;
    expect_v(K_BA, 32'd0, "pc_mark_ignored"); expect_v(K_PC, 32'h100, "pc_hold_100");
    step(); expect_v(K_PC, 32'h200, "pc_ld_no_inc");

    // Reset overrides same-cycle write/mark/increment
    step(); bus_bp.WE0 = 1'b1; bus_bp.WA0 = 4'd2; bus_bp.WD0 = 32'h77;
    bus_bp.MARKEN = 1'b1; bus_bp.MARKA = 4'd2;
    step(); bus_bp.RA = 4'd2; expect_v(K_A, 32'h77, "pre_rst_data"); expect_v(K_BA, 32'd1, "pre_rst_busy");
    step(); rst = 1'b1; bus_bp.PCEN = 1'b1;
    bus_bp.WE0 = 1'b1; bus_bp.WA0 = 4'd2; bus_bp.WD0 = 32'hDEAD;
    bus_bp.MARKEN = 1'b1; bus_bp.MARKA = 4'd2;
    expect_v(K_PC, 32'h200, "pc_pre_rst");
    step(); bus_bp.RA = 4'd2; bus_bp.RB = 4'd3;
    expect_v(K_A, 32'd0, "rst_reg2"); expect_v(K_BA, 32'd0, "rst_busy2"); expect_v(K_PC, 32'd0, "rst_pc");
    expect_v(K_B, 32'd0, "rst_reg3"); expect_v(K_NA, 32'd0, "nb_rst_reg2");

    // Drain with a bounded wait
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    if (sb_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_2w2r_sb.md
Name: regfile_2w2r_sb

Overview:
- Next-generation parametrised ARM register file with two combinational read ports and two synchronous write ports.
- Write port 0 carries ALU results; write port 1 carries load results.
- Includes an auto-incrementing PC register at a configurable index.
- Includes a per-register busy scoreboard for outstanding loads. Sits between decode (read addresses), the ALU/memory writeback paths and the hazard/stall logic.

Parameters:
- DW, 32: data width of every register, bits.
- AW, 4: register address width.
- NREG, 16: number of implemented registers; legal range 2..2**AW.
- PCIDX, 15: index of the PC register; must be < NREG.
- PCINC, 4: amount added to the PC register per enabled cycle.
- BYPASS, 1: 1 enables write-to-read forwarding on both read ports; 0 means registered values only.

Ports:
- CLK  in  1  register clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- RA  in  AW  read address, port A.
- RB  in  AW  read address, port B.
- A  out  DW  read data, port A.
- B  out  DW  read data, port B.
- BUSYA  out  1  register addressed by RA has an outstanding load.
- BUSYB  out  1  register addressed by RB has an outstanding load.
- WE0  in  1  write enable, ALU port.
- WA0  in  AW  write address, ALU port.
- WD0  in  DW  write data, ALU port.
- WE1  in  1  write enable, load port.
- WA1  in  AW  write address, load port.
- WD1  in  DW  write data, load port.
- PCEN  in  1  increment PC register this cycle.
- PC  out  DW  current registered PC value, i.e. reg[PCIDX] with no bypass.
- MARKEN  in  1  mark a register busy (load issued).
- MARKA  in  AW  register to mark.

Behaviour:
- Reset:
  - On a rising CLK edge with RST=1, every register is set to 0, every busy bit to 0, and PC to 0.
  - RST overrides any write, mark or increment in that cycle.
  - After reset, A=B=PC=0 and BUSYA=BUSYB=0.
- Writes:
  - On a rising edge with WEn=1 and WAn<NREG, reg[WAn] <= WDn.
  - WAn >= NREG is ignored.
  - Both ports writing the same address in one cycle: port 1 wins.
- PC register:
  - With PCEN=1 and no write targeting PCIDX: reg[PCIDX] <= reg[PCIDX] + PCINC, modulo 2**DW (wraps, no flag).
  - A write to PCIDX on either port overrides the increment that cycle; the written value is stored with no increment added.
- Reads:
  - A/B are combinational from RA/RB, with zero latency.
  - Address >= NREG reads as 0.
  - With BYPASS=1, if a write to RA (or RB) is enabled in the same cycle, A (or B) returns that write data; port 1 has priority over port 0.
  - A pending PC increment is never forwarded; reads of PCIDX return the registered value unless a real write is being bypassed.
  - With BYPASS=0, reads always return the registered value.
- Scoreboard, one busy bit per implemented register:
  - MARKEN=1 with MARKA<NREG and MARKA!=PCIDX sets busy[MARKA] on the edge.
  - Marks to PCIDX or to an out-of-range address are ignored.
  - WE1=1 clears busy[WA1] on the edge.
  - WE0 never changes busy bits.
  - MARKEN and WE1 to the same address in one cycle: busy ends set, because a new load was issued.
  - BUSYA = busy[RA], except that with BYPASS=1 it reads 0 when WE1=1 and WA1==RA (data is being forwarded). BUSYB is the same for RB.
  - Out-of-range read addresses give busy 0.
- Restrictions:
  - No clock gating and no asynchronous paths.
  - All outputs except A, B, BUSYA and BUSYB come directly from flops.

Test Plan:
- Reset, then PCEN=1 for 3 cycles -> PC=0,4,8,12 on successive cycles; reg[0..14] read as 0. Then preload reg[PCIDX]=0xFFFFFFFC via WE0 and hold PCEN=1 -> PC wraps to 0x00000000 after one edge.
- WE0=1, WA0=3, WD0=0xAAAA0000 together with WE1=1, WA1=3, WD1=0x5555FFFF in the same cycle, RA=3 -> A=0x5555FFFF during that cycle (bypass) and after the edge (port 1 wins).
- MARKEN=1, MARKA=5; next cycle RB=5 -> BUSYB=1. Then WE1=1, WA1=5, WD1=0x12345678 -> BUSYB=0 and B=0x12345678 in that same cycle; busy[5] is 0 after the edge.
- Same-cycle MARKEN=1, MARKA=7 and WE1=1, WA1=7, WD1=0x11 -> after the edge, reg[7]=0x11 and busy[7]=1.
- WE0=1, WA0=15, WD0=0x100 with PCEN=1 -> PC=0x100 after the edge (no +4). MARKEN=1, MARKA=15 -> busy stays 0.
- RST=1 asserted for one cycle while WE0=1, WA0=2 and MARKEN=1, MARKA=2 -> reg[2]=0, busy[2]=0 and PC=0 after the edge. Repeat the bypass scenario with BYPASS=0 -> A shows the old value until the edge.
